fpadd_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one IEEE-754 single-precision adder datapath (pre-adder alignment, mantissa add, normalise) between two requesters. It accepts operand pairs over valid/ready handshakes, grants one per cycle round-robin, drives the registered operands into the shared datapath, and tracks each in-flight operation's owner so that the sum returns to the correct requester. A drain control stops new issue and reports when the datapath pipeline is empty.

---
 rtl/fpadd_arbiter.sv | 136 +++++++++++++
 tb/tb_fpadd_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_arbiter.sv
// Two-port valid/ready arbiter feeding one shared FP adder pipeline and routing each sum back to its owner.
// Define FPADD_ARB_PRIO_EN for fixed priority (port 0 wins contention); otherwise round-robin.
module fpadd_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        dp_valid,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  input  logic [31:0] dp_result,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  input  logic        drain,
  output logic        idle
);

  localparam int CW = $clog2(LAT + 2);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_STOP} state_e;

  state_e        state_q, state_d;
  logic          grant_en;
  logic          gnt0, gnt1, xfer, retire;
  logic [LAT:0]  vld_pipe_q, own_pipe_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Arbitration
`ifdef FPADD_ARB_PRIO_EN
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
  end
`else
  logic ptr_q;  // last granted port

  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ptr_q);
    gnt1 = req1_valid & (~req0_valid | ~ptr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr_q <= 1'b1;
    else if (xfer) ptr_q <= req1_ready;
  end
`endif

  assign req0_ready = rst_n & grant_en & gnt0;
  assign req1_ready = rst_n & grant_en & gnt1;
  assign xfer       = req0_ready | req1_ready;
  assign retire     = vld_pipe_q[LAT];

  // Issue register into the shared datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid <= 1'b0;
      dp_a     <= '0;
      dp_b     <= '0;
    end else begin
      dp_valid <= xfer;
      if (xfer) begin
        dp_a <= req1_ready ? req1_a : req0_a;
        dp_b <= req1_ready ? req1_b : req0_b;
      end
    end
  end

  // Owner tracking: tail lines up with dp_result for the matching issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      own_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= xfer;
      own_pipe_q[0] <= req1_ready;
      for (int i = 1; i <= LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        own_pipe_q[i] <= own_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
    end else begin
      rsp0_valid <= retire & ~own_pipe_q[LAT];
      rsp1_valid <= retire &  own_pipe_q[LAT];
      if (retire) rsp_data <= dp_result;
    end
  end

  assign cnt_d = cnt_q + CW'(xfer) - CW'(retire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // FSM: state register / next state / outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (drain) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!drain)                          state_d = S_RUN;
        else if (cnt_q == '0 && !retire)     state_d = S_STOP;
      end
      S_STOP:  if (!drain) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // A drain raised this cycle already blocks the grant
  always_comb begin
    grant_en = (state_q == S_RUN) && !drain;
    idle     = (state_q == S_STOP);
  end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Bench for fpadd_arbiter: LAT=2 instance driven from a vector table, plus a LAT=0 instance for back-to-back issue.
module tb_fpadd_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        dp_valid, rsp0_valid, rsp1_valid, drain, idle;
  logic [31:0] dp_a, dp_b, dp_result, rsp_data;

  logic        z_req0_valid, z_req0_ready, z_req1_valid, z_req1_ready;
  logic [31:0] z_req0_a, z_req0_b, z_req1_a, z_req1_b;
  logic        z_dp_valid, z_rsp0_valid, z_rsp1_valid, z_drain, z_idle;
  logic [31:0] z_dp_a, z_dp_b, z_dp_result, z_rsp_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the adder: exact for 1.0+2.0, otherwise an arbitrary mixing of both operands
  function automatic logic [31:0] fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return {a[31:16] ^ b[15:0], a[15:0] + b[31:16]};
  endfunction

  logic [31:0] dp_pipe0, dp_pipe1;
  always @(posedge clk) begin
    dp_pipe0 <= fn(dp_a, dp_b);
    dp_pipe1 <= dp_pipe0;
  end
  assign dp_result   = dp_pipe1;
  assign z_dp_result = fn(z_dp_a, z_dp_b);

  fpadd_arbiter #(.LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .dp_valid(dp_valid), .dp_a(dp_a), .dp_b(dp_b), .dp_result(dp_result),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .drain(drain), .idle(idle)
  );

  fpadd_arbiter #(.LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(z_req0_valid), .req0_ready(z_req0_ready), .req0_a(z_req0_a), .req0_b(z_req0_b),
    .req1_valid(z_req1_valid), .req1_ready(z_req1_ready), .req1_a(z_req1_a), .req1_b(z_req1_b),
    .dp_valid(z_dp_valid), .dp_a(z_dp_a), .dp_b(z_dp_b), .dp_result(z_dp_result),
    .rsp0_valid(z_rsp0_valid), .rsp1_valid(z_rsp1_valid), .rsp_data(z_rsp_data),
    .drain(z_drain), .idle(z_idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {logic port; logic [31:0] data; int due;} rsp_t;
  typedef struct {logic [31:0] a; logic [31:0] b;} iss_t;
  rsp_t rq[$];
  rsp_t zq[$];
  iss_t iq[$];
  rsp_t m_rsp, z_rsp;
  iss_t m_iss;

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (dp_valid) begin
        if (iq.size() == 0) chk("dp_valid_unexpected", 32'(dp_valid), 32'd0);
        else begin
          m_iss = iq.pop_front();
          chk("dp_a", dp_a, m_iss.a);
          chk("dp_b", dp_b, m_iss.b);
        end
      end
      if (rsp0_valid || rsp1_valid) begin
        if (rq.size() == 0) chk("rsp_unexpected", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        else begin
          m_rsp = rq.pop_front();
          chk("rsp_port", 32'({rsp1_valid, rsp0_valid}), m_rsp.port ? 32'd2 : 32'd1);
          chk("rsp_data", rsp_data, m_rsp.data);
          chk("rsp_cycle", 32'(cyc), 32'(m_rsp.due));
        end
      end
      if (z_rsp0_valid || z_rsp1_valid) begin
        if (zq.size() == 0) chk("lat0_rsp_unexpected", 32'({z_rsp1_valid, z_rsp0_valid}), 32'd0);
        else begin
          z_rsp = zq.pop_front();
          chk("lat0_rsp_port", 32'({z_rsp1_valid, z_rsp0_valid}), 32'd2);
          chk("lat0_rsp_data", z_rsp_data, z_rsp.data);
          chk("lat0_rsp_cycle", 32'(cyc), 32'(z_rsp.due));
        end
      end
    end
  end

  typedef struct {
    logic v0; logic [31:0] a0; logic [31:0] b0;
    logic v1; logic [31:0] a1; logic [31:0] b1;
    logic drn; logic er0; logic er1; logic eidle;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic drn, input logic er0, input logic er1, input logic eidle);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.v1 = v1; v.a1 = a1; v.b1 = b1;
    v.drn = drn; v.er0 = er0; v.er1 = er1; v.eidle = eidle;
    return v;
  endfunction

  function automatic vec_t nop(input logic drn, input logic eidle);
    return mk(0, 32'h0, 32'h0, 0, 32'h0, 32'h0, drn, 0, 0, eidle);
  endfunction

  // Apply one row just after a rising edge, check at the falling edge, queue expected results
  task automatic apply(input vec_t v, input int idx);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    drain = v.drn;
    @(negedge clk);
    chk($sformatf("row%0d_ready", idx), 32'({req1_ready, req0_ready}), 32'({v.er1, v.er0}));
    chk($sformatf("row%0d_idle", idx), 32'(idle), 32'(v.eidle));
    if (req0_valid && v.er0) begin
      rq.push_back('{1'b0, fn(v.a0, v.b0), cyc + LAT + 2});
      iq.push_back('{v.a0, v.b0});
    end
    if (req1_valid && v.er1) begin
      rq.push_back('{1'b1, fn(v.a1, v.b1), cyc + LAT + 2});
      iq.push_back('{v.a1, v.b1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
    chk({tag, "_dp_valid"}, 32'(dp_valid), 32'd0);
    chk({tag, "_dp_a"}, dp_a, 32'd0);
    chk({tag, "_dp_b"}, dp_b, 32'd0);
    chk({tag, "_rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_idle"}, 32'(idle), 32'd0);
  endtask

  initial begin
    req0_valid = 1'b1; req1_valid = 1'b1; drain = 1'b0;
    req0_a = 32'h1; req0_b = 32'h2; req1_a = 32'h3; req1_b = 32'h4;
    z_req0_valid = 1'b0; z_req1_valid = 1'b0; z_drain = 1'b0;
    z_req0_a = '0; z_req0_b = '0; z_req1_a = '0; z_req1_b = '0;

    @(negedge clk);
    check_reset_vals("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention from reset: 0,1,0,1,0,1; losers hold operands (Inf/NaN on port 1)
    for (int i = 0; i < 6; i++)
      tv.push_back(mk(1, 32'h40000000 | 32'((i + 1) / 2), 32'h3F000000 | 32'((i + 1) / 2),
                      1, 32'hC0000000 | 32'(i / 2), 32'h7F800000 | 32'(i / 2),
                      0, (i % 2 == 0), (i % 2 == 1), 0));
    // Lone requester wins even if it was last granted (denormal operand)
    tv.push_back(mk(0, 32'h0, 32'h0, 1, 32'h00000001, 32'h80000000, 0, 0, 1, 0));
    tv.push_back(mk(1, 32'h3F800000, 32'h40000000, 0, 32'h0, 32'h0, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) tv.push_back(nop(0, 0));
    // Hold: port 0 loses, then granted with unchanged operands
    tv.push_back(mk(1, 32'h11111111, 32'h22222222, 1, 32'h33333333, 32'h44444444, 0, 0, 1, 0));
    tv.push_back(mk(1, 32'h11111111, 32'h22222222, 1, 32'h55555555, 32'h66666666, 0, 1, 0, 0));
    tv.push_back(mk(0, 32'h0, 32'h0, 1, 32'h55555555, 32'h66666666, 0, 0, 1, 0));
    for (int i = 0; i < 5; i++) tv.push_back(nop(0, 0));
    // Drain with three in flight
    tv.push_back(mk(1, 32'hA1, 32'hA2, 0, 32'h0, 32'h0, 0, 1, 0, 0));
    tv.push_back(mk(0, 32'h0, 32'h0, 1, 32'hB1, 32'hB2, 0, 0, 1, 0));
    tv.push_back(mk(1, 32'hC1, 32'hC2, 0, 32'h0, 32'h0, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(1, 32'hD1, 32'hD2, 1, 32'hE1, 32'hE2, 1, 0, 0, 0));
    tv.push_back(mk(1, 32'hD1, 32'hD2, 1, 32'hE1, 32'hE2, 1, 0, 0, 1));
    tv.push_back(mk(1, 32'hD1, 32'hD2, 1, 32'hE1, 32'hE2, 1, 0, 0, 1));
    tv.push_back(mk(1, 32'hD1, 32'hD2, 1, 32'hE1, 32'hE2, 0, 0, 0, 1));
    tv.push_back(mk(1, 32'hD1, 32'hD2, 1, 32'hE1, 32'hE2, 0, 0, 1, 0));
    tv.push_back(mk(1, 32'hD1, 32'hD2, 0, 32'h0, 32'h0, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) tv.push_back(nop(0, 0));
    // Drain with an empty pipeline: idle two cycles after drain rises
    tv.push_back(nop(1, 0));
    tv.push_back(nop(1, 0));
    tv.push_back(nop(1, 1));
    tv.push_back(mk(1, 32'hF1, 32'hF2, 0, 32'h0, 32'h0, 0, 0, 0, 1));
    tv.push_back(mk(1, 32'hF1, 32'hF2, 0, 32'h0, 32'h0, 0, 1, 0, 0));
    // Drain dropped before the pipeline empties
    tv.push_back(mk(0, 32'h0, 32'h0, 1, 32'h12345678, 32'h9ABCDEF0, 0, 0, 1, 0));
    tv.push_back(mk(1, 32'h0F0F0F0F, 32'hF0F0F0F0, 0, 32'h0, 32'h0, 1, 0, 0, 0));
    tv.push_back(mk(1, 32'h0F0F0F0F, 32'hF0F0F0F0, 0, 32'h0, 32'h0, 0, 0, 0, 0));
    tv.push_back(mk(1, 32'h0F0F0F0F, 32'hF0F0F0F0, 0, 32'h0, 32'h0, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) tv.push_back(nop(0, 0));

    foreach (tv[i]) apply(tv[i], i);

    // Reset with two operations outstanding: nothing may come back
    apply(mk(1, 32'h7FC00001, 32'h1, 0, 32'h0, 32'h0, 0, 1, 0, 0), 900);
    apply(mk(0, 32'h0, 32'h0, 1, 32'hFF800000, 32'h2, 0, 0, 1, 0), 901);
    rst_n = 1'b0;
    rq.delete();
    iq.delete();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check_reset_vals("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) apply(nop(0, 0), 910 + i);
    apply(mk(1, 32'h1, 32'h2, 1, 32'h3, 32'h4, 0, 1, 0, 0), 920);
    for (int i = 0; i < 5; i++) apply(nop(0, 0), 921 + i);

    // LAT=0 instance: back-to-back port 1 transfers
    for (int i = 0; i < 4; i++) begin
      z_req1_valid = 1'b1;
      z_req1_a = 32'hA0000000 + 32'(i);
      z_req1_b = 32'h00010000 * 32'(i + 1);
      @(negedge clk);
      chk($sformatf("lat0_ready%0d", i), 32'({z_req1_ready, z_req0_ready}), 32'd2);
      if (z_req1_ready) zq.push_back('{1'b1, fn(z_req1_a, z_req1_b), cyc + 2});
      @(posedge clk); #1;
    end
    z_req1_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);

    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    chk("issue_queue_empty", 32'(iq.size()), 32'd0);
    chk("lat0_queue_empty", 32'(zq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
